// File: rtl/out_port_fifo.sv
// rtl/out_port_fifo.sv - first-word-fall-through output-port buffer with stall request and sticky overflow
module out_port_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int SKID   = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       stalledx3,
  input  logic                       dataoutvx3,
  input  logic [DATA_W-1:0]          dataoutx3,
  output logic [DATA_W-1:0]          port_data,
  output logic                       port_valid,
  input  logic                       port_ready,
  output logic                       out_stall,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW-1:0]     rptr_nxt;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] head;
  logic              ovf;
  logic              push;
  logic              pop;
  logic              accept;

  // Pop is only possible when a word is presented; a push is taken while
  // there is room, or when full if the head leaves in the same cycle.
  assign push     = dataoutvx3 & ~stalledx3;
  assign pop      = port_valid & port_ready;
  assign accept   = push & ((cnt < CW'(DEPTH)) | pop);
  assign rptr_nxt = rptr + 1'b1;

  // All outputs come straight from registers, so no input reaches an output
  assign port_valid = (cnt != '0);
  assign port_data  = head;
  assign out_stall  = (cnt >= CW'(DEPTH - SKID));
  assign overflow   = ovf;
  assign count      = cnt;

  // Storage array; contents need no reset because pointers and count define validity
  always_ff @(posedge clock) begin
    if (accept) begin
      mem[wptr] <= dataoutx3;
    end
  end

  // Pointers, occupancy and the sticky drop flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (accept) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr_nxt;
      end
      case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (push && !accept) begin
        ovf <= 1'b1;
      end
    end
  end

  // Head register: loads the next word on pop or on a push into an empty
  // buffer, and otherwise keeps the last word, so it holds the last popped
  // word while empty.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
    end else if (accept && cnt == '0) begin
      head <= dataoutx3;
    end else if (pop && cnt > CW'(1)) begin
      head <= mem[rptr_nxt];
    end else if (pop && accept) begin
      head <= dataoutx3;
    end
  end

endmodule

// File: tb/tb_out_port_fifo.sv
// tb/tb_out_port_fifo.sv - self-checking bench for out_port_fifo
module tb_out_port_fifo;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int SKID   = 2;
  localparam int CW     = $clog2(DEPTH+1);

  logic              clock = 1'b0;
  logic              reset_n;
  logic              stalledx3;
  logic              dataoutvx3;
  logic [DATA_W-1:0] dataoutx3;
  logic [DATA_W-1:0] port_data;
  logic              port_valid;
  logic              port_ready;
  logic              out_stall;
  logic              overflow;
  logic [CW-1:0]     count;

  always #5 clock = ~clock;

  out_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SKID(SKID)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .stalledx3  (stalledx3),
    .dataoutvx3 (dataoutvx3),
    .dataoutx3  (dataoutx3),
    .port_data  (port_data),
    .port_valid (port_valid),
    .port_ready (port_ready),
    .out_stall  (out_stall),
    .overflow   (overflow),
    .count      (count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: an ordered queue of buffered words, the last word that
  // left the port, and a sticky drop flag.
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] last;
  bit                movf;

  task automatic model_reset();
    q.delete();
    last = '0;
    movf = 1'b0;
  endtask

  task automatic check_model(input string nm);
    logic [DATA_W-1:0] exp_head;
    exp_head = (q.size() != 0) ? q[0] : last;
    chk({nm, " valid"},    32'(port_valid), 32'(q.size() != 0));
    chk({nm, " data"},     32'(port_data),  32'(exp_head));
    chk({nm, " count"},    32'(count),      32'(q.size()));
    chk({nm, " stall"},    32'(out_stall),  32'(q.size() >= DEPTH - SKID));
    chk({nm, " overflow"}, 32'(overflow),   32'(movf));
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge
  task automatic cyc(input bit v, input bit s, input logic [DATA_W-1:0] d, input bit r, input string nm);
    dataoutvx3 = v;
    stalledx3  = s;
    dataoutx3  = d;
    port_ready = r;
    if (r && q.size() != 0) last = q.pop_front();
    if (v && !s) begin
      if (q.size() < DEPTH) q.push_back(d);
      else movf = 1'b1;
    end
    @(posedge clock);
    #1;
    check_model(nm);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, " valid"},    32'(port_valid), 32'd0);
    chk({nm, " data"},     32'(port_data),  32'd0);
    chk({nm, " count"},    32'(count),      32'd0);
    chk({nm, " stall"},    32'(out_stall),  32'd0);
    chk({nm, " overflow"}, 32'(overflow),   32'd0);
  endtask

  typedef struct {
    bit                v;
    bit                s;
    logic [DATA_W-1:0] d;
    bit                r;
    bit                ev;
    logic [DATA_W-1:0] ed;
    int                ec;
    bit                es;
    bit                eo;
  } vec_t;

  vec_t tbl[17];
  int   rmode;
  bit   rv, rs, rr;

  initial begin
    // fill with port_ready=0, including a dropped 9th word
    tbl[0]  = '{1, 0, 16'h0001, 0, 1, 16'h0001, 1, 0, 0};
    tbl[1]  = '{1, 0, 16'h0002, 0, 1, 16'h0001, 2, 0, 0};
    tbl[2]  = '{1, 0, 16'h0003, 0, 1, 16'h0001, 3, 0, 0};
    tbl[3]  = '{1, 0, 16'h0004, 0, 1, 16'h0001, 4, 0, 0};
    tbl[4]  = '{1, 0, 16'h0005, 0, 1, 16'h0001, 5, 0, 0};
    tbl[5]  = '{1, 0, 16'h0006, 0, 1, 16'h0001, 6, 1, 0};
    tbl[6]  = '{1, 0, 16'h0007, 0, 1, 16'h0001, 7, 1, 0};
    tbl[7]  = '{1, 0, 16'h0008, 0, 1, 16'h0001, 8, 1, 0};
    tbl[8]  = '{1, 0, 16'h0009, 0, 1, 16'h0001, 8, 1, 1};
    // drain with port_ready=1 from full
    tbl[9]  = '{0, 0, 16'h0000, 1, 1, 16'h0002, 7, 1, 1};
    tbl[10] = '{0, 0, 16'h0000, 1, 1, 16'h0003, 6, 1, 1};
    tbl[11] = '{0, 0, 16'h0000, 1, 1, 16'h0004, 5, 0, 1};
    tbl[12] = '{0, 0, 16'h0000, 1, 1, 16'h0005, 4, 0, 1};
    tbl[13] = '{0, 0, 16'h0000, 1, 1, 16'h0006, 3, 0, 1};
    tbl[14] = '{0, 0, 16'h0000, 1, 1, 16'h0007, 2, 0, 1};
    tbl[15] = '{0, 0, 16'h0000, 1, 1, 16'h0008, 1, 0, 1};
    tbl[16] = '{0, 0, 16'h0000, 1, 0, 16'h0008, 0, 0, 1};

    // reset held with a valid word on the input
    reset_n    = 1'b0;
    dataoutvx3 = 1'b1;
    stalledx3  = 1'b0;
    dataoutx3  = 16'h00A5;
    port_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("in reset");
    reset_n = 1'b1;
    model_reset();
    cyc(1, 0, 16'h00A5, 0, "first push");
    cyc(0, 0, 16'h0000, 1, "pop to empty");

    // stalled words are bubbles
    for (int i = 0; i < 5; i++) cyc(1, 1, 16'hBEEF, 0, "bubble");

    // table-driven fill / overflow / drain
    for (int i = 0; i < 17; i++) begin
      dataoutvx3 = tbl[i].v;
      stalledx3  = tbl[i].s;
      dataoutx3  = tbl[i].d;
      port_ready = tbl[i].r;
      @(posedge clock);
      #1;
      chk($sformatf("tbl%0d valid", i),    32'(port_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d data", i),     32'(port_data),  32'(tbl[i].ed));
      chk($sformatf("tbl%0d count", i),    32'(count),      32'(tbl[i].ec));
      chk($sformatf("tbl%0d stall", i),    32'(out_stall),  32'(tbl[i].es));
      chk($sformatf("tbl%0d overflow", i), 32'(overflow),   32'(tbl[i].eo));
    end

    // asynchronous reset clears the sticky flag at once
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    reset_n = 1'b1;
    model_reset();

    // push while full with a simultaneous pop: accepted, emerges last
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 16'h0010 + 16'(i), 0, "fill2");
    cyc(1, 0, 16'h0042, 1, "full push+pop");
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 16'h0000, 1, "drain2");

    // several pointer laps at full with push and pop every cycle
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 16'h0100 + 16'(i), 0, "fill3");
    for (int i = 0; i < 3 * DEPTH; i++) cyc(1, 0, 16'h0200 + 16'(i), 1, "lap");
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 16'h0000, 1, "drain3");

    // randomized traffic against the model, with a mid-run reset
    rmode = 0;
    for (int c = 0; c < 2000; c++) begin
      if (c % 100 == 0) rmode = int'($urandom_range(0, 2));
      if (c == 1000) begin
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid reset");
        model_reset();
        #1;
        reset_n = 1'b1;
      end
      rv = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 4) == 0);
      case (rmode)
        0:       rr = ($urandom_range(0, 3) == 0);
        1:       rr = ($urandom_range(0, 3) != 0);
        default: rr = ($urandom_range(0, 1) == 0);
      endcase
      cyc(rv, rs, 16'($urandom), rr, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
